// File: rtl/rf_wb_ctrl_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : rf_ctrl_pkg                                                     |
// | Purpose  : Shared widths and write-back source encoding for rf_wb_ctrl.    |
// | Revision : 1.0                                                             |
// +----------------------------------------------------------------------------+
package rf_ctrl_pkg;
  localparam int DATA_W    = 16;
  localparam int REG_SEL_W = 3;
  localparam int NUM_REGS  = 2 ** REG_SEL_W;

  typedef enum logic {
    SRC_EX  = 1'b0,
    SRC_MEM = 1'b1
  } wb_src_e;
endpackage
`default_nettype wire

// File: rtl/rf_wb_ctrl_if.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : rf_wb_ctrl_if                                                   |
// | Purpose  : Issue, write-back handshake and regFile write-port bundle.      |
// | Revision : 1.0                                                             |
// +----------------------------------------------------------------------------+
interface rf_wb_ctrl_if #(
  parameter int DATA_W    = rf_ctrl_pkg::DATA_W,
  parameter int REG_SEL_W = rf_ctrl_pkg::REG_SEL_W,
  parameter int NUM_REGS  = rf_ctrl_pkg::NUM_REGS
) ();
  logic                 issue_valid;
  logic [REG_SEL_W-1:0] issue_src1;
  logic [REG_SEL_W-1:0] issue_src2;
  logic                 issue_src1_en;
  logic                 issue_src2_en;
  logic [REG_SEL_W-1:0] issue_dst;
  logic                 issue_wr;
  logic                 stall;
  logic                 ex_valid;
  logic [REG_SEL_W-1:0] ex_sel;
  logic [DATA_W-1:0]    ex_data;
  logic                 ex_ready;
  logic                 mem_valid;
  logic [REG_SEL_W-1:0] mem_sel;
  logic [DATA_W-1:0]    mem_data;
  logic                 mem_ready;
  logic                 writeEn;
  logic [REG_SEL_W-1:0] writeRegSel;
  logic [DATA_W-1:0]    writeData;
  logic [NUM_REGS-1:0]  busy;
  logic                 err;

  modport slave (
    input  issue_valid, issue_src1, issue_src2, issue_src1_en, issue_src2_en,
    input  issue_dst, issue_wr,
    input  ex_valid, ex_sel, ex_data, mem_valid, mem_sel, mem_data,
    output stall, ex_ready, mem_ready,
    output writeEn, writeRegSel, writeData, busy, err
  );

  modport master (
    output issue_valid, issue_src1, issue_src2, issue_src1_en, issue_src2_en,
    output issue_dst, issue_wr,
    output ex_valid, ex_sel, ex_data, mem_valid, mem_sel, mem_data,
    input  stall, ex_ready, mem_ready,
    input  writeEn, writeRegSel, writeData, busy, err
  );
endinterface
`default_nettype wire

// File: rtl/rf_wb_ctrl_scoreboard.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : rf_scoreboard                                                   |
// | Purpose  : Per-register busy bits and RAW/WAW issue stall.                 |
// | Revision : 1.0                                                             |
// +----------------------------------------------------------------------------+
module rf_scoreboard
  import rf_ctrl_pkg::*;
#(
  parameter int REG_SEL_W = rf_ctrl_pkg::REG_SEL_W,
  parameter int NUM_REGS  = rf_ctrl_pkg::NUM_REGS
) (
  input  wire logic                 clk,
  input  wire logic                 rst,
  input  wire logic                 issue_valid,
  input  wire logic [REG_SEL_W-1:0] issue_src1,
  input  wire logic [REG_SEL_W-1:0] issue_src2,
  input  wire logic                 issue_src1_en,
  input  wire logic                 issue_src2_en,
  input  wire logic [REG_SEL_W-1:0] issue_dst,
  input  wire logic                 issue_wr,
  input  wire logic                 clr_en,
  input  wire logic [REG_SEL_W-1:0] clr_sel,
  output logic                      stall,
  output logic                      issue_accept,
  output logic [NUM_REGS-1:0]       busy
);
  logic [NUM_REGS-1:0] busy_q;
  logic [NUM_REGS-1:0] busy_d;

  always_comb begin
    stall = issue_valid & ((issue_src1_en & busy_q[issue_src1]) |
                           (issue_src2_en & busy_q[issue_src2]) |
                           (issue_wr      & busy_q[issue_dst]));
    issue_accept = issue_valid & ~stall;
  end

  // WAW stall keeps set and clear off the same register, so order is irrelevant
  always_comb begin
    busy_d = busy_q;
    if (clr_en) busy_d[clr_sel] = 1'b0;
    if (issue_accept && issue_wr) busy_d[issue_dst] = 1'b1;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) busy_q <= '0;
    else      busy_q <= busy_d;
  end

  assign busy = busy_q;
endmodule
`default_nettype wire

// File: rtl/rf_wb_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : rf_wb_ctrl                                                      |
// | Purpose  : Round-robin EX/MEM write-back arbiter onto the regFile port.    |
// | Revision : 1.0                                                             |
// +----------------------------------------------------------------------------+
module rf_wb_ctrl
  import rf_ctrl_pkg::*;
#(
  parameter int DATA_W    = rf_ctrl_pkg::DATA_W,
  parameter int REG_SEL_W = rf_ctrl_pkg::REG_SEL_W,
  parameter int NUM_REGS  = rf_ctrl_pkg::NUM_REGS
) (
  input  wire logic   clk,
  input  wire logic   rst,
  rf_wb_ctrl_if.slave bus
);
  logic                 write_en_q,  write_en_d;
  logic [REG_SEL_W-1:0] write_sel_q, write_sel_d;
  logic [DATA_W-1:0]    write_data_q, write_data_d;
  wb_src_e              last_grant_q, last_grant_d;
  logic                 err_q, err_d;

  logic                 grant_ex;
  logic                 grant_mem;
  logic                 xfer;
  logic [REG_SEL_W-1:0] xfer_sel;
  logic [DATA_W-1:0]    xfer_data;
  logic                 issue_accept;
  logic [NUM_REGS-1:0]  busy;

  rf_scoreboard #(
    .REG_SEL_W (REG_SEL_W),
    .NUM_REGS  (NUM_REGS)
  ) u_scoreboard (
    .clk           (clk),
    .rst           (rst),
    .issue_valid   (bus.issue_valid),
    .issue_src1    (bus.issue_src1),
    .issue_src2    (bus.issue_src2),
    .issue_src1_en (bus.issue_src1_en),
    .issue_src2_en (bus.issue_src2_en),
    .issue_dst     (bus.issue_dst),
    .issue_wr      (bus.issue_wr),
    .clr_en        (write_en_q),
    .clr_sel       (write_sel_q),
    .stall         (bus.stall),
    .issue_accept  (issue_accept),
    .busy          (busy)
  );

  // Grants are gated by rst so nothing handshakes while reset is held
  always_comb begin
    grant_ex  = rst & bus.ex_valid  & (~bus.mem_valid | (last_grant_q == SRC_MEM));
    grant_mem = rst & bus.mem_valid & (~bus.ex_valid  | (last_grant_q == SRC_EX));
    xfer      = grant_ex | grant_mem;
    xfer_sel  = grant_mem ? bus.mem_sel  : bus.ex_sel;
    xfer_data = grant_mem ? bus.mem_data : bus.ex_data;
  end

  always_comb begin
    write_en_d   = xfer;
    write_sel_d  = xfer ? xfer_sel  : write_sel_q;
    write_data_d = xfer ? xfer_data : write_data_q;
    last_grant_d = last_grant_q;
    if (grant_ex)  last_grant_d = SRC_EX;
    if (grant_mem) last_grant_d = SRC_MEM;
    err_d = err_q
          | (xfer & ~busy[xfer_sel])
          | (bus.ex_valid & bus.mem_valid & (bus.ex_sel == bus.mem_sel))
          | (issue_accept & bus.issue_wr & busy[bus.issue_dst]);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      write_en_q   <= 1'b0;
      write_sel_q  <= '0;
      write_data_q <= '0;
      last_grant_q <= SRC_EX;
      err_q        <= 1'b0;
    end else begin
      write_en_q   <= write_en_d;
      write_sel_q  <= write_sel_d;
      write_data_q <= write_data_d;
      last_grant_q <= last_grant_d;
      err_q        <= err_d;
    end
  end

  assign bus.ex_ready    = grant_ex;
  assign bus.mem_ready   = grant_mem;
  assign bus.writeEn     = write_en_q;
  assign bus.writeRegSel = write_sel_q;
  assign bus.writeData   = write_data_q;
  assign bus.busy        = busy;
  assign bus.err         = err_q;
endmodule
`default_nettype wire
